// File: rtl/ysyx_25020037_ifu_fetch_if.sv
// Fetch-unit handshake bundle: decode-side valid/ready, execute redirect,
// and the single-outstanding valid/ready instruction memory port.
interface ysyx_25020037_ifu_fetch_if;
    logic        idu_ready;
    logic        ifu_valid;
    logic [63:0] fu_to_du_bus;
    logic        exu_dnpc_valid;
    logic [31:0] dnpc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    modport master (
        input  idu_ready, exu_dnpc_valid, dnpc, req_ready,
        input  resp_valid, resp_data, resp_err,
        output ifu_valid, fu_to_du_bus, req_valid, req_addr
    );

    modport slave (
        output idu_ready, exu_dnpc_valid, dnpc, req_ready,
        output resp_valid, resp_data, resp_err,
        input  ifu_valid, fu_to_du_bus, req_valid, req_addr
    );
endinterface

// File: rtl/ysyx_25020037_ifu_fetch.sv
// Instruction fetch unit: owns the PC, keeps one fetch in flight and hands
// {pc, inst} to decode; redirects squash in-flight or held wrong-path fetches.
module ysyx_25020037_ifu_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h3000_0000,
    parameter logic [31:0] ILLEGAL_INST = 32'hFFFF_FFFF
) (
    input  logic                           clk,
    input  logic                           rst,
    ysyx_25020037_ifu_fetch_if.master      ifc
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        req_valid_q, req_valid_d;
    logic        ifu_valid_q, ifu_valid_d;
    logic [63:0] bus_q, bus_d;
    logic        redirect;

    assign redirect = ifc.exu_dnpc_valid;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        bus_d   = bus_q;

        case (state_q)
            S_REQ: begin
                // A request accepted in a redirect cycle is already wrong-path.
                if (req_valid_q && ifc.req_ready) begin
                    state_d = S_WAIT;
                    drop_d  = redirect;
                end
            end
            S_WAIT: begin
                if (ifc.resp_valid) begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                    if (!drop_q && !redirect) begin
                        bus_d   = {pc_q, ifc.resp_err ? ILLEGAL_INST : ifc.resp_data};
                        state_d = S_HOLD;
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect || ifc.idu_ready) begin
                    state_d = S_REQ;
                    if (!redirect) begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (redirect) begin
            pc_d = ifc.dnpc;
        end

        // The redirect cycle leaves a one-cycle gap before the new-path request.
        req_valid_d = (state_d == S_REQ) && !redirect;
        ifu_valid_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            req_valid_q <= 1'b0;
            ifu_valid_q <= 1'b0;
            bus_q       <= 64'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            req_valid_q <= req_valid_d;
            ifu_valid_q <= ifu_valid_d;
            bus_q       <= bus_d;
        end
    end

    assign ifc.req_valid    = req_valid_q;
    assign ifc.req_addr     = pc_q;
    assign ifc.ifu_valid    = ifu_valid_q;
    assign ifc.fu_to_du_bus = bus_q;

endmodule
